// File: rtl/fpnew_norm_stage_if.sv
// Handshake/data bundle between the FMA/adder datapath, the normalization
// stage and the rounding block. The rounding mode is 3 bits wide; RNE encodes as 0.
interface fpnew_norm_stage_if #(
  parameter int ExpBits      = 8,
  parameter int ManBits      = 23,
  parameter int SumWidth     = 48,
  parameter int RsrPrecision = 12,
  parameter int TagWidth     = 4
);
  logic                        in_valid_i;
  logic                        in_ready_o;
  logic                        in_sign_i;
  logic signed [ExpBits+1:0]   in_exp_i;
  logic [SumWidth-1:0]         in_sum_i;
  logic [2:0]                  in_rnd_mode_i;
  logic                        in_eff_sub_i;
  logic [TagWidth-1:0]         in_tag_i;
  logic                        out_valid_o;
  logic                        out_ready_i;
  logic [ExpBits+ManBits-1:0]  out_abs_value_o;
  logic [1:0]                  out_round_sticky_o;
  logic [RsrPrecision-1:0]     out_stoch_bits_o;
  logic                        out_sign_o;
  logic [2:0]                  out_rnd_mode_o;
  logic                        out_eff_sub_o;
  logic [TagWidth-1:0]         out_tag_o;
  logic                        out_overflow_o;
  logic                        out_zero_o;

  modport slave (
    input  in_valid_i, in_sign_i, in_exp_i, in_sum_i, in_rnd_mode_i, in_eff_sub_i, in_tag_i,
           out_ready_i,
    output in_ready_o, out_valid_o, out_abs_value_o, out_round_sticky_o, out_stoch_bits_o,
           out_sign_o, out_rnd_mode_o, out_eff_sub_o, out_tag_o, out_overflow_o, out_zero_o
  );

  modport master (
    output in_valid_i, in_sign_i, in_exp_i, in_sum_i, in_rnd_mode_i, in_eff_sub_i, in_tag_i,
           out_ready_i,
    input  in_ready_o, out_valid_o, out_abs_value_o, out_round_sticky_o, out_stoch_bits_o,
           out_sign_o, out_rnd_mode_o, out_eff_sub_o, out_tag_o, out_overflow_o, out_zero_o
  );
endinterface

// File: rtl/fpnew_norm_stage.sv
// Normalization stage ahead of rounding: LZC normalize / subnormal denormalize /
// overflow detect, then one valid/ready register holding the rounding-ready bundle.
module fpnew_norm_stage #(
  parameter int ExpBits      = 8,
  parameter int ManBits      = 23,
  parameter int SumWidth     = 48,
  parameter int RsrPrecision = 12,
  parameter int TagWidth     = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  fpnew_norm_stage_if.slave  bus
);
  localparam int EW  = ExpBits + 2;
  localparam int LZW = $clog2(SumWidth);
  localparam int SHW = $clog2(SumWidth + 1);
  localparam int RND = SumWidth - 2 - ManBits;

  localparam logic signed [EW-1:0] S_ONE  = EW'(1);
  localparam logic signed [EW-1:0] OVF_TH = EW'((2 ** ExpBits) - 1);
  localparam logic signed [EW:0]   R_ONE  = (EW+1)'(1);
  localparam logic signed [EW:0]   R_SAT  = (EW+1)'(SumWidth);
  localparam logic [SumWidth-1:0]  LOW_MASK = {SumWidth{1'b1}} >> (ManBits + 2);

  generate
    if (SumWidth < ManBits + 1 + RsrPrecision) begin : g_bad_width
      $error("fpnew_norm_stage: SumWidth must be >= ManBits+1+RsrPrecision");
    end
  endgenerate

  typedef struct packed {
    logic [ExpBits+ManBits-1:0] abs_value;
    logic [1:0]                 round_sticky;
    logic [RsrPrecision-1:0]    stoch;
    logic                       sign;
    logic [2:0]                 rnd_mode;
    logic                       eff_sub;
    logic [TagWidth-1:0]        tag;
    logic                       overflow;
    logic                       zero;
  } resp_t;

  logic signed [EW-1:0]  exp_s, e_norm;
  logic signed [EW:0]    rsh_full;
  logic [LZW-1:0]        lzc, lsh;
  logic [SHW-1:0]        rsh;
  logic [2*SumWidth-1:0] rwide;
  logic [SumWidth-1:0]   shifted;
  logic                  is_zero, deep, norm, ovf, spill, sticky;
  logic [ExpBits-1:0]    exp_f;
  logic                  vld_q, load;
  resp_t                 nxt, q;

  assign exp_s = bus.in_exp_i;

  // Highest set bit wins: later (higher) iterations overwrite lower ones.
  always_comb begin
    lzc = '0;
    for (int i = 0; i < SumWidth; i++)
      if (bus.in_sum_i[i]) lzc = LZW'(SumWidth - 1 - i);
  end

  assign is_zero = ~|bus.in_sum_i;
  assign e_norm  = exp_s - $signed(EW'(lzc));
  // Deep is decided on in_exp alone, so a wrapped e_norm never matters there.
  assign deep    = exp_s < S_ONE;
  assign norm    = ~deep & (e_norm >= S_ONE);
  assign ovf     = ~is_zero & ~deep & (e_norm >= OVF_TH);

  // One extra bit so 1 - in_exp cannot wrap for the most negative exponent.
  assign rsh_full = R_ONE - $signed({exp_s[EW-1], exp_s});
  assign rsh      = (rsh_full > R_SAT) ? SHW'(SumWidth) : rsh_full[SHW-1:0];
  assign lsh      = norm ? lzc : LZW'(exp_s - S_ONE);

  assign rwide   = {bus.in_sum_i, {SumWidth{1'b0}}} >> rsh;
  assign shifted = deep ? rwide[2*SumWidth-1 -: SumWidth] : (bus.in_sum_i << lsh);
  assign spill   = deep & (|rwide[SumWidth-1:0]);
  assign sticky  = (|(shifted & LOW_MASK)) | spill;
  assign exp_f   = norm ? e_norm[ExpBits-1:0] : '0;

  always_comb begin
    nxt          = '0;
    nxt.sign     = bus.in_sign_i;
    nxt.rnd_mode = bus.in_rnd_mode_i;
    nxt.eff_sub  = bus.in_eff_sub_i;
    nxt.tag      = bus.in_tag_i;
    if (is_zero) begin
      nxt.zero = 1'b1;
    end else if (ovf) begin
      nxt.overflow  = 1'b1;
      nxt.abs_value = {{ExpBits{1'b1}}, {ManBits{1'b0}}};
      nxt.stoch     = shifted[RND -: RsrPrecision];
    end else begin
      nxt.abs_value    = {exp_f, shifted[SumWidth-2 -: ManBits]};
      nxt.round_sticky = {shifted[RND], sticky};
      nxt.stoch        = shifted[RND -: RsrPrecision];
    end
  end

  assign bus.in_ready_o = ~vld_q | bus.out_ready_i;
  assign load           = bus.in_valid_i & bus.in_ready_o & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= 1'b0;
      q     <= '0;
    end else begin
      if (flush_i)               vld_q <= 1'b0;
      else if (load)             vld_q <= 1'b1;
      else if (bus.out_ready_i)  vld_q <= 1'b0;
      if (load) q <= nxt;
    end
  end

  assign bus.out_valid_o        = vld_q;
  assign bus.out_abs_value_o    = q.abs_value;
  assign bus.out_round_sticky_o = q.round_sticky;
  assign bus.out_stoch_bits_o   = q.stoch;
  assign bus.out_sign_o         = q.sign;
  assign bus.out_rnd_mode_o     = q.rnd_mode;
  assign bus.out_eff_sub_o      = q.eff_sub;
  assign bus.out_tag_o          = q.tag;
  assign bus.out_overflow_o     = q.overflow;
  assign bus.out_zero_o         = q.zero;
endmodule

// File: doc/fpnew_norm_stage.md
# fpnew_norm_stage

Pipelined normalization stage sitting directly upstream of the FP rounding block. It takes an unnormalized wide magnitude with a biased exponent, as produced by the FMA/adder datapath. It performs leading-zero normalization, subnormal denormalization and overflow detection, then registers a rounding-ready bundle: packed {exponent, mantissa}, round/sticky bits, stochastic-rounding bits and sign. A single valid/ready pipeline register decouples it from the rounding stage.

## Interface
- ExpBits, 8, exponent field width
- ManBits, 23, mantissa field width (no hidden bit)
- SumWidth, 48, width of unnormalized magnitude; elaboration error unless SumWidth ≥ ManBits+1+RsrPrecision
- RsrPrecision, 12, number of stochastic-rounding bits forwarded
- TagWidth, 4, opaque tag passed through

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous kill of the held entry
- in_valid_i  in  1  input valid
- in_ready_o  out  1  input ready
- in_sign_i  in  1  result sign
- in_exp_i  in  ExpBits+2  signed biased exponent weighting in_sum_i[SumWidth-1]
- in_sum_i  in  SumWidth  unsigned magnitude, MSB has weight 2^(in_exp_i−bias)
- in_rnd_mode_i  in  fpnew_pkg::roundmode_e  passed through
- in_eff_sub_i  in  1  effective subtraction, passed through
- in_tag_i  in  TagWidth  passed through
- out_valid_o  out  1  output valid
- out_ready_i  in  1  downstream ready
- out_abs_value_o  out  ExpBits+ManBits  {exp, mantissa}
- out_round_sticky_o  out  2  {round, sticky}
- out_stoch_bits_o  out  RsrPrecision  bits directly below the mantissa LSB
- out_sign_o, out_rnd_mode_o, out_eff_sub_o, out_tag_o  out  —  registered pass-through
- out_overflow_o  out  1  exponent overflow before rounding
- out_zero_o  out  1  in_sum_i was all zero

## Operation
- Combinational LZC on in_sum_i gives lzc (0..SumWidth−1). e_norm = in_exp_i − lzc, computed signed in ExpBits+2 bits.
- Zero: when in_sum_i == 0, abs = 0, RS = 00, stoch = 0, zero = 1, overflow = 0.
- Normal, when e_norm ≥ 1:
  - Shift left by lzc.
  - Exponent field = e_norm.
- Partial subnormal, when in_exp_i ≥ 1 and e_norm < 1:
  - Shift left by in_exp_i−1.
  - Exponent field = 0.
- Deep subnormal, when in_exp_i < 1:
  - Shift right by 1−in_exp_i, saturating at SumWidth.
  - Bits shifted out OR into sticky.
  - Exponent field = 0.
- Field extraction from the shifted value s:
  - Mantissa = s[SumWidth−2 -: ManBits]; the hidden bit s[SumWidth−1] is dropped.
  - Round = next bit down.
  - Sticky = OR of all lower bits plus right-shift spill.
  - stoch = the RsrPrecision bits starting at the round position.
- Overflow: when e_norm ≥ 2^ExpBits−1, overflow = 1, abs = {all-ones, 0}, RS = 00.
- Pipeline register handshake:
  - in_ready_o = ~out_valid_o | out_ready_i.
  - Load on in_valid_i & in_ready_o. Output fields change only on load.
  - out_valid_o clears on out_ready_i with no load.
  - Simultaneous accept and drain gives back-to-back throughput of 1 per cycle.
- flush_i: out_valid_o ← 0 next cycle and in_ready_o high. Flush beats a concurrent load; the incoming beat is dropped.

## Timing
- Latency: exactly 1 cycle from accepted input to out_valid_o.
- Throughput: 1 per cycle.
- out_valid_o must hold, with data stable, while out_ready_i is low.
- Reset, asynchronous: out_valid_o = 0 and every registered output = 0, with out_rnd_mode_o = RNE (encoding 0). in_ready_o = 1 during and after reset.
- Reset asserted mid-transfer discards the held entry; no beat reappears after release.
- in_ready_o has a combinational path from out_ready_i only. There is no path from in_valid_i.

## Test plan
- Normal: in_exp = 130, in_sum = 48'h8000_0000_0000 → one cycle later abs = {8'd130, 23'd0}, RS = 00, stoch = 0.
- LZC: in_exp = 130, in_sum = 48'h0000_0100_0000 (lzc = 23) → abs = {8'd107, 23'd0}, RS = 00.
- Round/sticky: in_exp = 127, in_sum = 48'h8000_0080_0001 → abs = {8'd127, 0}, RS = 11, stoch = 12'h800.
- Subnormal: in_exp = −2, in_sum = MSB only → abs = {8'd0, 23'h100000}, RS = 00.
- Deep subnormal: in_exp = −60 → abs = 0, RS = 01.
- Overflow: in_exp = 300 → overflow = 1, abs = {8'hFF, 0}.
- Zero: in_sum = 0 → zero = 1.
- Backpressure:
  - 3 back-to-back beats with out_ready_i low for 2 cycles → in_ready_o low, output stable, no beat lost or duplicated, order preserved.
  - flush_i with a held beat → out_valid_o = 0 next cycle.
  - rst_ni pulse mid-stream → all outputs 0.
